// File: rtl/lif_pkg.sv
// Shared types and constants for the time-multiplexed LIF neuron array.
package lif_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } lif_state_e;

    localparam int LIF_WIDTH   = 8;
    localparam int REFRAC_W    = 4;
    localparam int SPIKE_CNT_W = 8;
    localparam logic [SPIKE_CNT_W-1:0] SPIKE_CNT_MAX = 8'hFF;
    localparam int POP_IN_W    = 16;
    localparam int POP_OUT_W   = 5;

    function automatic logic [POP_OUT_W-1:0] popcount16(input logic [POP_IN_W-1:0] v);
        logic [POP_OUT_W-1:0] n;
        n = '0;
        for (int i = 0; i < POP_IN_W; i++) begin
            n = n + POP_OUT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/lif_array_scheduler_if.sv
// Step handshake, weight config, debug read and spike result bundle of the LIF scheduler.
interface lif_array_scheduler_if #(
    parameter int NUM_NEURONS = 4,
    parameter int WIDTH       = 8
);
    localparam int ADDR_W = $clog2(NUM_NEURONS);

    logic                   step_valid;
    logic                   step_ready;
    logic [WIDTH-1:0]       current;
    logic                   cfg_we;
    logic [ADDR_W-1:0]      cfg_addr;
    logic [WIDTH-1:0]       cfg_weight;
    logic [ADDR_W-1:0]      rd_addr;
    logic [WIDTH-1:0]       rd_state;
    logic                   busy;
    logic                   spike_valid;
    logic [NUM_NEURONS-1:0] spikes;
    logic [7:0]             spike_count;

    modport master (
        output step_valid, current, cfg_we, cfg_addr, cfg_weight, rd_addr,
        input  step_ready, rd_state, busy, spike_valid, spikes, spike_count
    );

    modport slave (
        input  step_valid, current, cfg_we, cfg_addr, cfg_weight, rd_addr,
        output step_ready, rd_state, busy, spike_valid, spikes, spike_count
    );

endinterface

// File: rtl/lif_neuron_update.sv
// Combinational leak / integrate / threshold / refractory step for one neuron.
module lif_neuron_update
    import lif_pkg::*;
#(
    parameter int WIDTH        = LIF_WIDTH,
    parameter int THRESHOLD    = 128,
    parameter int LEAK_SHIFT   = 1,
    parameter int REFRAC_STEPS = 2
) (
    input  logic [WIDTH-1:0]    state_i,
    input  logic [REFRAC_W-1:0] refrac_i,
    input  logic [WIDTH-1:0]    current_i,
    input  logic [WIDTH-1:0]    weight_i,
    output logic [WIDTH-1:0]    state_o,
    output logic [REFRAC_W-1:0] refrac_o,
    output logic                spike_o
);

    logic [WIDTH-1:0]   leaked;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     sum;

    // sum is one bit wider than the state so the threshold test never sees a wrapped value
    always_comb begin
        leaked   = state_i - (state_i >> LEAK_SHIFT);
        product  = (2*WIDTH)'(current_i) * (2*WIDTH)'(weight_i);
        sum      = {1'b0, leaked} + {1'b0, product[2*WIDTH-1:WIDTH]};
        state_o  = '0;
        refrac_o = '0;
        spike_o  = 1'b0;
        if (refrac_i != '0) begin
            refrac_o = refrac_i - REFRAC_W'(1);
        end else if (sum >= (WIDTH+1)'(THRESHOLD)) begin
            spike_o  = 1'b1;
            refrac_o = REFRAC_W'(REFRAC_STEPS);
        end else begin
            state_o = sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/lif_array_scheduler.sv
// Walks NUM_NEURONS virtual LIF neurons through one shared update datapath per timestep
// and publishes the resulting spike vector.
module lif_array_scheduler
    import lif_pkg::*;
#(
    parameter int NUM_NEURONS  = 4,
    parameter int WIDTH        = LIF_WIDTH,
    parameter int THRESHOLD    = 128,
    parameter int LEAK_SHIFT   = 1,
    parameter int REFRAC_STEPS = 2,
    parameter int WEIGHT_INIT  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lif_array_scheduler_if.slave  bus
);

    localparam int ADDR_W = $clog2(NUM_NEURONS);

    lif_state_e             fsm_q;
    logic [ADDR_W-1:0]      idx_q;
    logic [WIDTH-1:0]       current_q;
    logic [WIDTH-1:0]       membrane_q [NUM_NEURONS];
    logic [REFRAC_W-1:0]    refrac_q   [NUM_NEURONS];
    logic [WIDTH-1:0]       weight_q   [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] spikeAcc_q;
    logic [NUM_NEURONS-1:0] spikes_q;
    logic                   spikeValid_q;
    logic [SPIKE_CNT_W-1:0] spikeCount_q;
    logic                   stepReady_q;
    logic                   busy_q;

    logic [WIDTH-1:0]       membrane_d;
    logic [REFRAC_W-1:0]    refrac_d;
    logic                   spike_d;
    logic [SPIKE_CNT_W:0]   cntSum;
    logic [SPIKE_CNT_W-1:0] spikeCount_d;

    // The neuron under update reads the weight register directly, so a same-cycle
    // write to that neuron only lands after its update has been taken.
    lif_neuron_update #(
        .WIDTH        (WIDTH),
        .THRESHOLD    (THRESHOLD),
        .LEAK_SHIFT   (LEAK_SHIFT),
        .REFRAC_STEPS (REFRAC_STEPS)
    ) u_update (
        .state_i   (membrane_q[idx_q]),
        .refrac_i  (refrac_q[idx_q]),
        .current_i (current_q),
        .weight_i  (weight_q[idx_q]),
        .state_o   (membrane_d),
        .refrac_o  (refrac_d),
        .spike_o   (spike_d)
    );

    always_comb begin
        cntSum       = {1'b0, spikeCount_q} + (SPIKE_CNT_W+1)'(popcount16(POP_IN_W'(spikeAcc_q)));
        spikeCount_d = cntSum[SPIKE_CNT_W] ? SPIKE_CNT_MAX : cntSum[SPIKE_CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q        <= IDLE;
            idx_q        <= '0;
            current_q    <= '0;
            spikeAcc_q   <= '0;
            spikes_q     <= '0;
            spikeValid_q <= 1'b0;
            spikeCount_q <= '0;
            stepReady_q  <= 1'b1;
            busy_q       <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                membrane_q[i] <= '0;
                refrac_q[i]   <= '0;
                weight_q[i]   <= WIDTH'(WEIGHT_INIT);
            end
        end else begin
            spikeValid_q <= 1'b0;
            if (bus.cfg_we) begin
                weight_q[bus.cfg_addr] <= bus.cfg_weight;
            end
            unique case (fsm_q)
                IDLE: begin
                    if (bus.step_valid) begin
                        fsm_q       <= UPDATE;
                        idx_q       <= '0;
                        current_q   <= bus.current;
                        spikeAcc_q  <= '0;
                        stepReady_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                UPDATE: begin
                    membrane_q[idx_q] <= membrane_d;
                    refrac_q[idx_q]   <= refrac_d;
                    spikeAcc_q[idx_q] <= spike_d;
                    if (idx_q == ADDR_W'(NUM_NEURONS - 1)) begin
                        fsm_q <= DONE;
                    end else begin
                        idx_q <= idx_q + ADDR_W'(1);
                    end
                end
                DONE: begin
                    spikes_q     <= spikeAcc_q;
                    spikeValid_q <= 1'b1;
                    spikeCount_q <= spikeCount_d;
                    stepReady_q  <= 1'b1;
                    busy_q       <= 1'b0;
                    fsm_q        <= IDLE;
                end
                default: begin
                    fsm_q       <= IDLE;
                    stepReady_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.step_ready  = stepReady_q;
    assign bus.busy        = busy_q;
    assign bus.spike_valid = spikeValid_q;
    assign bus.spikes      = spikes_q;
    assign bus.spike_count = spikeCount_q;
    assign bus.rd_state    = membrane_q[bus.rd_addr];

endmodule

// File: tb/tb_lif_array_scheduler.sv
// Directed scoreboard bench for lif_array_scheduler (N=4, THRESHOLD=128, LEAK_SHIFT=1, REFRAC_STEPS=2).
module tb_lif_array_scheduler;

    typedef struct packed {
        logic [3:0] spikes;
        logic [7:0] count;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t expQ[$];

    lif_array_scheduler_if #(.NUM_NEURONS(4), .WIDTH(8)) bus ();

    lif_array_scheduler #(
        .NUM_NEURONS  (4),
        .WIDTH        (8),
        .THRESHOLD    (128),
        .LEAK_SHIFT   (1),
        .REFRAC_STEPS (2),
        .WEIGHT_INIT  (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic checkState(input string name, input logic [1:0] addr, input int expected);
        bus.rd_addr = addr;
        #1;
        checkOutput(name, int'(bus.rd_state), expected);
    endtask

    task automatic waitSpikeValid(input int budget, output int lat);
        lat = 0;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            if (bus.spike_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    // Issues one step from IDLE, queues its expected result and checks the N+1 edge latency.
    task automatic applyStimulus(input logic [7:0] cur, input logic [3:0] expSpikes, input logic [7:0] expCount);
        exp_t e;
        int   lat;
        e.spikes = expSpikes;
        e.count  = expCount;
        checkOutput("step_ready_before_step", int'(bus.step_ready), 1);
        expQ.push_back(e);
        bus.step_valid = 1'b1;
        bus.current    = cur;
        @(posedge clk);
        #1;
        bus.step_valid = 1'b0;
        bus.cfg_we     = 1'b0;
        checkOutput("busy_after_accept", int'(bus.busy), 1);
        waitSpikeValid(20, lat);
        checkOutput("spike_valid_latency", lat, 5);
    endtask

    task automatic writeWeight(input logic [1:0] addr, input logic [7:0] w);
        bus.cfg_we     = 1'b1;
        bus.cfg_addr   = addr;
        bus.cfg_weight = w;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
    endtask

    // Scoreboard monitor: every spike_valid pulse must match the oldest queued step.
    always @(negedge clk) begin
        if (rst_n && bus.spike_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_spike_valid", 1, 0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("spikes", int'(bus.spikes), int'(e.spikes));
                checkOutput("spike_count", int'(bus.spike_count), int'(e.count));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0] s3Spk  [3];
        logic [7:0] s3Cnt  [3];
        logic [3:0] s4Spk  [8];
        logic [7:0] s4Cnt  [8];
        int         s4Rd1  [8];
        int         s4Rd0  [8];
        int         lat;
        exp_t       e;

        s3Spk = '{4'b0000, 4'b0000, 4'b0001};
        s3Cnt = '{8'd1, 8'd1, 8'd2};
        s4Spk = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        s4Cnt = '{8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd4};
        s4Rd1 = '{50, 75, 88, 94, 97, 99, 100, 100};
        s4Rd0 = '{0, 0, 99, 0, 0, 0, 99, 0};

        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus.step_valid = 1'b0;
        bus.current    = '0;
        bus.cfg_we     = 1'b0;
        bus.cfg_addr   = '0;
        bus.cfg_weight = '0;
        bus.rd_addr    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state after idling
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_step_ready", int'(bus.step_ready), 1);
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_spikes", int'(bus.spikes), 0);
        checkOutput("reset_spike_valid", int'(bus.spike_valid), 0);
        checkOutput("reset_spike_count", int'(bus.spike_count), 0);
        for (int a = 0; a < 4; a++) checkState("reset_rd_state", 2'(a), 0);

        // Single spike on neuron 0
        writeWeight(2'd0, 8'd255);
        applyStimulus(8'd255, 4'b0001, 8'd1);
        checkState("s2_rd_state0", 2'd0, 0);

        // Refractory hold on neuron 0
        for (int s = 0; s < 3; s++) applyStimulus(8'd255, s3Spk[s], s3Cnt[s]);

        // Sub-threshold integration on neuron 1 while neuron 0 keeps cycling
        writeWeight(2'd1, 8'd128);
        for (int s = 0; s < 8; s++) begin
            applyStimulus(8'd100, s4Spk[s], s4Cnt[s]);
            checkState("s4_rd_state1", 2'd1, s4Rd1[s]);
            checkState("s4_rd_state0", 2'd0, s4Rd0[s]);
        end

        // Reset in the middle of a step, with an ignored step request during UPDATE
        repeat (2) @(posedge clk);
        #1;
        bus.current    = 8'd255;
        bus.step_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.step_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.step_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.step_valid = 1'b0;
        rst_n          = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("s5_step_ready_after_reset", int'(bus.step_ready), 1);
        checkOutput("s5_busy_after_reset", int'(bus.busy), 0);
        checkOutput("s5_spike_count_after_reset", int'(bus.spike_count), 0);
        checkOutput("s5_spikes_after_reset", int'(bus.spikes), 0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            checkOutput("s5_no_spike_valid", int'(bus.spike_valid), 0);
        end
        for (int a = 0; a < 4; a++) checkState("s5_rd_state", 2'(a), 0);

        // Weight write to neuron 2 during its own update cycle uses the old weight
        e.spikes = 4'b0000;
        e.count  = 8'd0;
        expQ.push_back(e);
        bus.current    = 8'd255;
        bus.step_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.step_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.step_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.step_valid = 1'b0;
        bus.cfg_we     = 1'b1;
        bus.cfg_addr   = 2'd2;
        bus.cfg_weight = 8'd255;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        waitSpikeValid(20, lat);
        checkOutput("s6_spike_valid_latency", lat, 2);
        checkState("s6_rd_state2_old_weight", 2'd2, 0);
        applyStimulus(8'd255, 4'b0100, 8'd1);

        // Weight write together with the step accept takes effect in that step
        bus.cfg_we     = 1'b1;
        bus.cfg_addr   = 2'd3;
        bus.cfg_weight = 8'd255;
        applyStimulus(8'd255, 4'b1000, 8'd2);
        checkOutput("s6_spikes_hold", int'(bus.spikes), 4'b1000);

        repeat (8) @(posedge clk);
        #1;
        checkOutput("s6_spikes_hold_later", int'(bus.spikes), 4'b1000);
        checkOutput("scoreboard_drained", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
